// File: rtl/end_tick_pkg.sv
// rtl/end_tick_pkg.sv - shared state encoding and defaults for the end-of-run detector
package end_tick_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_QUIET = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEFAULT_QUIET_CYCLES = 4;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter with synchronous clear that holds at all-ones
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             at_max_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign at_max_o = &cnt_q;
  assign cnt_o    = cnt_q;

  // Clear wins over enable so a restart never carries a stale count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !at_max_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/end_tick.sv
// rtl/end_tick.sv - end-of-run detector: quiet-window end, result latch, halt strobe (optional END_TICK_TIMEOUT_EN watchdog)
module end_tick
  import end_tick_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int CNT_WIDTH      = 32,
  parameter int QUIET_CYCLES   = DEFAULT_QUIET_CYCLES,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  busy,
  input  logic                  res_valid,
  input  logic [DATA_WIDTH-1:0] res_data,
  output logic                  halt,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [CNT_WIDTH-1:0]  cycles,
  output logic                  timeout
);

  localparam int QW = (QUIET_CYCLES < 2) ? 1 : $clog2(QUIET_CYCLES + 1);

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  result_q, result_d;
  logic                   halt_q, halt_d;
  logic                   timeout_q, timeout_d;

  logic                   cyc_clr, cyc_en, cyc_at_max;
  logic [CNT_WIDTH-1:0]   cyc_cnt;
  logic                   q_clr, q_en, q_unused_max;
  logic [QW-1:0]          q_cnt;
  logic                   res_we;
  logic                   wd_trip;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
    .clk_i    (clk),
    .rst_ni   (rst),
    .clr_i    (cyc_clr),
    .en_i     (cyc_en),
    .cnt_o    (cyc_cnt),
    .at_max_o (cyc_at_max)
  );

  sat_counter #(.WIDTH(QW)) u_quiet_cnt (
    .clk_i    (clk),
    .rst_ni   (rst),
    .clr_i    (q_clr),
    .en_i     (q_en),
    .cnt_o    (q_cnt),
    .at_max_o (q_unused_max)
  );

`ifdef END_TICK_TIMEOUT_EN
  // Trip on the edge where the run counter lands on the limit, so it freezes there.
  assign wd_trip = ((state_q == ST_RUN) || (state_q == ST_QUIET)) && !cyc_at_max &&
                   (cyc_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
  logic unused_wd;
  assign unused_wd = ^{TIMEOUT_CYCLES, cyc_at_max};
  assign wd_trip   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cyc_clr = 1'b0;
    cyc_en  = 1'b0;
    q_clr   = 1'b0;
    q_en    = 1'b0;
    res_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cyc_clr = 1'b1;
          q_clr   = 1'b1;
        end
      end
      ST_RUN: begin
        cyc_en = 1'b1;
        res_we = res_valid;
        if (!busy) begin
          state_d = ST_QUIET;
          q_en    = 1'b1;
        end else begin
          q_clr = 1'b1;
        end
      end
      ST_QUIET: begin
        cyc_en = 1'b1;
        res_we = res_valid;
        if (busy) begin
          state_d = ST_RUN;
          q_clr   = 1'b1;
        end else if (q_cnt == QW'(QUIET_CYCLES)) begin
          state_d = ST_DONE;
        end else begin
          q_en = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (wd_trip) begin
      state_d = ST_DONE;
    end
  end

  always_comb begin
    result_d  = res_we ? res_data : result_q;
    halt_d    = (state_d == ST_DONE) && (state_q != ST_DONE);
    timeout_d = timeout_q | wd_trip;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      halt_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      halt_q    <= halt_d;
      timeout_q <= timeout_d;
    end
  end

  assign halt    = halt_q;
  assign done    = (state_q == ST_DONE);
  assign result  = result_q;
  assign cycles  = cyc_cnt;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_end_tick.sv
// tb/tb_end_tick.sv - directed self-checking bench for end_tick (QUIET_CYCLES 4 and 1)
module tb_end_tick;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        busy = 1'b0;
  logic        res_valid = 1'b0;
  logic [63:0] res_data = '0;

  logic        halt, done, timeout;
  logic [63:0] result;
  logic [31:0] cycles;
  logic        halt1, done1, timeout1;
  logic [63:0] result1;
  logic [31:0] cycles1;

  int n_checks = 0;
  int n_errors = 0;

  end_tick #(.DATA_WIDTH(64), .CNT_WIDTH(32), .QUIET_CYCLES(4), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .res_valid(res_valid),
    .res_data(res_data), .halt(halt), .done(done), .result(result),
    .cycles(cycles), .timeout(timeout)
  );

  end_tick #(.DATA_WIDTH(64), .CNT_WIDTH(32), .QUIET_CYCLES(1), .TIMEOUT_CYCLES(50)) dut_q1 (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .res_valid(res_valid),
    .res_data(res_data), .halt(halt1), .done(done1), .result(result1),
    .cycles(cycles1), .timeout(timeout1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded, checks=%0d", n_checks);
    $fatal(1, "bench stalled");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0; busy = 1'b0; res_valid = 1'b0; res_data = '0;
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // start at edge 0 with busy high; busy sampled high on edges 1..9, low afterwards
  task automatic normal_run(input string tag);
    start = 1'b1; busy = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_cyc0"}, cycles, 0);
    for (int e = 1; e <= 9; e++) begin
      res_valid = (e == 9);
      res_data  = (e == 9) ? 64'h1F4 : 64'h777;
      step();
      check({tag, "_run_nohalt"}, {done, halt}, 0);
    end
    check({tag, "_res_latched"}, result, 64'h1F4);
    res_valid = 1'b0; busy = 1'b0;
    for (int e = 10; e <= 13; e++) begin
      step();
      check({tag, "_quiet_nohalt"}, {done, halt}, 0);
    end
    step();
    check({tag, "_halt"}, {done, halt}, 2'b11);
    check({tag, "_cycles"}, cycles, 14);
    check({tag, "_result"}, result, 64'h1F4);
    step();
    check({tag, "_halt_once"}, {done, halt}, 2'b10);
    check({tag, "_cycles_frozen"}, cycles, 14);
  endtask

  initial begin
    int halt_cnt;
    int halt_edge;

    // Reset and idle
    do_reset();
    check("rst_state", {halt, done, timeout, result, cycles}, 0);
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_outs", {halt, done, timeout, |result, |cycles}, 0);
    end
    busy = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    check("idle_start_cyc0", cycles, 0);
    step();
    check("idle_start_cyc1", cycles, 1);

    // Normal end, then post-done immunity
    do_reset();
    normal_run("normal");
    start = 1'b1; busy = 1'b1; res_valid = 1'b1; res_data = 64'hDEAD;
    halt_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      halt_cnt += int'(halt);
    end
    check("post_done_result", result, 64'h1F4);
    check("post_done_cycles", cycles, 14);
    check("post_done_nohalt", halt_cnt, 0);
    check("post_done_done", done, 1);

    // Minimum run, both quiet windows
    do_reset();
    start = 1'b1; busy = 1'b0;
    step();
    start = 1'b0;
    halt_cnt = 0; halt_edge = -1;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (halt1) check("q1_halt_edge", e, 2);
      if (halt) begin
        halt_cnt++;
        if (halt_edge < 0) halt_edge = e;
      end
    end
    check("min_halt_edge", halt_edge, 5);
    check("min_halt_count", halt_cnt, 1);
    check("min_cycles", cycles, 5);
    check("q1_cycles", cycles1, 2);
    check("q1_done", done1, 1);

    // Glitch: 3-cycle gap in busy, then final drop
    do_reset();
    start = 1'b1; busy = 1'b1;
    step();
    start = 1'b0;
    halt_cnt = 0; halt_edge = -1;
    for (int e = 1; e <= 24; e++) begin
      busy = (e <= 4) || (e >= 8 && e <= 10);
      step();
      if (halt) begin
        halt_cnt++;
        if (halt_edge < 0) halt_edge = e;
      end
    end
    check("glitch_halt_count", halt_cnt, 1);
    check("glitch_halt_edge", halt_edge, 15);
    check("glitch_cycles", cycles, 15);

    // Reset mid-run in QUIET, then a fresh normal run
    do_reset();
    start = 1'b1; busy = 1'b1;
    step();
    start = 1'b0; res_valid = 1'b1; res_data = 64'h55;
    step();
    res_valid = 1'b0; busy = 1'b0;
    step();
    check("mid_pre_result", result, 64'h55);
    check("mid_pre_cycles", cycles, 2);
    #3;
    rst = 1'b0;
    #1;
    check("mid_async_rst", {halt, done, timeout, result, cycles}, 0);
    step();
    rst = 1'b1;
    normal_run("rerun");

    // Watchdog stimulus: busy held high
    do_reset();
    start = 1'b1; busy = 1'b1;
    step();
    start = 1'b0;
    halt_cnt = 0; halt_edge = -1;
    for (int e = 1; e <= 60; e++) begin
      step();
      if (halt) begin
        halt_cnt++;
        if (halt_edge < 0) halt_edge = e;
      end
    end
`ifdef END_TICK_TIMEOUT_EN
    check("wd_halt_edge", halt_edge, 50);
    check("wd_halt_count", halt_cnt, 1);
    check("wd_timeout", timeout, 1);
    check("wd_cycles", cycles, 50);
`else
    check("wd_off_halt_count", halt_cnt, 0);
    check("wd_off_timeout", timeout, 0);
    check("wd_off_cycles", cycles, 60);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/end_tick.md
# end_tick

Counterpart to the first-tick pulse generator: the first-tick pulse marks the start of a run; this block detects and signals the end of it. It arms on a start pulse, counts run cycles while the datapath is busy, and declares the run finished after the datapath has been idle for a programmable quiet window. It then latches the last valid result, emits a one-cycle `halt` strobe, and holds `done` until reset. It sits at the top level beside the first-tick generator and drives the simulation halt and the answer display.

## Interface
- `DATA_WIDTH`, 64, width of result bus
- `CNT_WIDTH`, 32, width of run-cycle counter
- `QUIET_CYCLES`, 4, consecutive idle cycles required to declare end (≥1)
- `TIMEOUT_CYCLES`, 1000000, watchdog limit (used only with macro)

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  arm pulse (normally first-tick output); level-tolerant, only rising sample in IDLE matters
- `busy`  in  1  datapath still working
- `res_valid`  in  1  `res_data` is a valid (partial or final) result this cycle
- `res_data`  in  DATA_WIDTH  result value
- `halt`  out  1  one-cycle strobe on end of run
- `done`  out  1  sticky end-of-run level
- `result`  out  DATA_WIDTH  last `res_data` captured with `res_valid`
- `cycles`  out  CNT_WIDTH  cycles spent in RUN+QUIET
- `timeout`  out  1  sticky watchdog flag

## Operation
- Reset values: `halt`=0, `done`=0, `result`=0, `cycles`=0, `timeout`=0, state=IDLE, quiet counter=0.
- States: IDLE, RUN, QUIET, DONE.
- IDLE: `start`=1 → RUN; `cycles` cleared to 0 on that edge. Other inputs ignored.
- RUN: `cycles`+1 each cycle (saturates at all-ones). `busy`=0 → QUIET, quiet counter=1.
- QUIET: `cycles`+1. `busy`=1 → RUN, quiet counter=0. Else quiet counter+1; if counter reaches `QUIET_CYCLES` → DONE with `halt` asserted that cycle.
- DONE: terminal until reset; `halt` only on entry cycle; `done`=1; `cycles`, `result` frozen; all inputs ignored, including further `start`.
- `result` updates with `res_data` whenever `res_valid`=1 in RUN or QUIET, including the cycle of the DONE transition. Same-cycle `res_valid` and end: the captured value is the one latched.
- `busy`=1 and `start`=1 together in IDLE: enter RUN; busy is evaluated from the next cycle.
- `QUIET_CYCLES`=1: end is declared on the first idle cycle after RUN.
- Reset mid-run: all state returns to reset values immediately; the next `start` begins a fresh run.

## Timing
- `halt` is registered: it asserts the cycle after the `QUIET_CYCLES`-th consecutive sampled `busy`=0 in RUN/QUIET, and `done` rises the same cycle.
- Minimum run: `start` at edge 0, `busy`=0 throughout, `QUIET_CYCLES`=4 → `halt` high after edge 5, `cycles`=5.
- `result` is visible one cycle after the `res_valid` sample.

## Configuration
- `END_TICK_TIMEOUT_EN` defined: in RUN/QUIET, when `cycles` reaches `TIMEOUT_CYCLES`, go to DONE, pulse `halt`, set `timeout`=1. This has priority over a simultaneous normal end; `timeout` stays sticky until reset.
- Not defined: no watchdog logic; `timeout` tied to 0; `TIMEOUT_CYCLES` unused.

## Structure
- Shared package `end_tick_pkg`: state enum type (IDLE, RUN, QUIET, DONE) and the default `QUIET_CYCLES` constant.
- One sub-module, `sat_counter` (parameterised width, clear, enable, saturate), used for both the run-cycle and quiet counters.

## Test plan
- Reset and idle: `rst` low then high, `start`=0 for 20 cycles, then `start`=1 → all outputs 0 during the idle cycles; `cycles` counts from 0 once `start`=1.
- Normal end: `start`, `busy`=1 for 10 cycles, then 0, `res_valid` with 0x1F4 on last busy cycle → single `halt` pulse 4 cycles after `busy` falls, `result`=0x1F4, `cycles`=14, `done` stays 1.
- Glitch: `busy` drops for 3 cycles then rises, later drops for good → no `halt` during the 3-cycle gap; exactly one `halt` after the final 4 idle cycles.
- Post-done immunity: after `done`, drive `start`, `busy`, `res_valid` with 0xDEAD → `result`, `cycles` unchanged and no second `halt`.
- Reset mid-run: `rst` low in QUIET → outputs 0 asynchronously; a new run behaves as in the normal-end scenario.
- Watchdog (macro on, `TIMEOUT_CYCLES`=50): `busy` held at 1 → `halt` and `timeout`=1 at `cycles`=50. With the macro off, the same stimulus gives no `halt` and `timeout`=0.
